// File: rtl/csa_row_resolver_if.sv
// Handshake and data bundle between the compressor tree, the resolver and the result register.
interface csa_row_resolver_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_row;
    logic [WIDTH-1:0] carry_row;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [1:0]       ovf;
    logic             busy;

    modport master (
        output in_valid, sum_row, carry_row, out_ready,
        input  in_ready, out_valid, result, ovf, busy
    );

    modport slave (
        input  in_valid, sum_row, carry_row, out_ready,
        output in_ready, out_valid, result, ovf, busy
    );
endinterface

// File: rtl/csa_row_resolver.sv
// Resolves a redundant SUM/CARRY row pair into one binary result, CHUNK bits per cycle,
// least-significant slice first, with a registered carry between slices.
module csa_row_resolver #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input logic                clk,
    input logic                rst_n,
    csa_row_resolver_if.slave  bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              cy_q, cy_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              msb_q, msb_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [1:0]        ovf_q, ovf_d;
    logic [CHUNK:0]    slice_sum;

    always_comb begin
        slice_sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, cy_q};
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cy_d     = cy_q;
        a_d      = a_q;
        b_d      = b_q;
        msb_d    = msb_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.sum_row;
                    // CARRY row has weight i+1; its top bit falls outside the result width.
                    b_d     = {bus.carry_row[WIDTH-2:0], 1'b0};
                    msb_d   = bus.carry_row[WIDTH-1];
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                result_d[idx_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                cy_d  = slice_sum[CHUNK];
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    ovf_d   = {1'b0, slice_sum[CHUNK]} + {1'b0, msb_q};
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            msb_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cy_q     <= cy_d;
            a_q      <= a_d;
            b_q      <= b_d;
            msb_q    <= msb_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_csa_row_resolver.sv
// Directed bench for csa_row_resolver; an arithmetic reference model is checked every cycle.
module tb_csa_row_resolver;
    localparam int unsigned WIDTH  = 64;
    localparam int unsigned NCHUNK = 4;

    logic clk;
    logic rst_n;

    csa_row_resolver_if #(.WIDTH(WIDTH)) bus ();

    csa_row_resolver #(
        .WIDTH (WIDTH),
        .CHUNK (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [1:0]  ovf;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Exact sum of the redundant pair, including the two bits above the result width.
    function automatic logic [65:0] model(input logic [63:0] s, input logic [63:0] c);
        return {2'b00, s} + {1'b0, c, 1'b0};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction bookkeeping on the active edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                logic [65:0] e;
                exp_t        t;
                e     = model(bus.sum_row, bus.carry_row);
                t.res = e[63:0];
                t.ovf = e[65:64];
                q.push_back(t);
                acc_cyc = cyc;
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_ov;
            exp_ov = (q.size() != 0) && ((cyc - acc_cyc) >= NCHUNK);
            check("in_ready", bus.in_ready, q.size() == 0);
            check("busy", bus.busy, q.size() != 0);
            check("out_valid", bus.out_valid, exp_ov);
            if (bus.out_valid && q.size() != 0) begin
                check("result", bus.result, q[0].res);
                check("ovf", bus.ovf, q[0].ovf);
            end
        end
    end

    task automatic wait_accept();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        check("accept_timeout", k >= 50, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) break;
        end
        check("out_timeout", bus.out_valid, 1);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_txn(input string name, input logic [63:0] s, input logic [63:0] c,
                           input logic [63:0] exp_res, input logic [1:0] exp_ovf);
        int lat;
        bus.sum_row   = s;
        bus.carry_row = c;
        bus.in_valid  = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        wait_out(lat);
        check({name, "_latency"}, lat, NCHUNK);
        check({name, "_result"}, bus.result, exp_res);
        check({name, "_ovf"}, bus.ovf, exp_ovf);
        release_out();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_result"}, bus.result, 0);
        check({name, "_ovf"}, bus.ovf, 0);
        check({name, "_in_ready"}, bus.in_ready, 1);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        int lat;
        int last_acc;
        logic [63:0] ones;
        ones          = '1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sum_row   = '0;
        bus.carry_row = '0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Hand-computed pins on the model itself.
        check("model_simple", model(64'h5, 64'h3), 66'hB);
        check("model_ripple1", model(ones, 64'h1), {2'b01, 64'h1});
        check("model_ripple2", model(ones, ones), {2'b10, 64'hFFFF_FFFF_FFFF_FFFD});

        run_txn("simple", 64'h5, 64'h3, 64'hB, 2'd0);
        run_txn("cross", 64'hFFFF, 64'h1, 64'h1_0001, 2'd0);
        run_txn("ripple1", ones, 64'h1, 64'h1, 2'd1);
        run_txn("ripple2", ones, ones, 64'hFFFF_FFFF_FFFF_FFFD, 2'd2);
        run_txn("top_bit", 64'h0, 64'h8000_0000_0000_0000, 64'h0, 2'd1);

        // Backpressure: DONE held while new data waits on the input.
        bus.sum_row   = 64'h1234;
        bus.carry_row = 64'h10;
        bus.in_valid  = 1'b1;
        wait_accept();
        bus.sum_row   = 64'hDEAD_BEEF_0000_1111;
        bus.carry_row = 64'h7777;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_result", bus.result, 64'h1254);
            check("bp_ovf", bus.ovf, 0);
            check("bp_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        check("bp_still_valid", bus.out_valid, 1);
        release_out();
        bus.sum_row   = 64'hABCD_0000_0000_0000;
        bus.carry_row = 64'h8000;
        wait_accept();
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("bp_next_result", bus.result, 64'hABCD_0000_0001_0000);
        release_out();

        // Reset after the second ADD slice.
        bus.sum_row   = 64'h0000_0000_7777_7777;
        bus.carry_row = 64'h0000_0000_0101_0101;
        bus.in_valid  = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_partial_nonzero", bus.result != 0, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", bus.in_ready, 1);
        run_txn("post_reset", 64'h5, 64'h3, 64'hB, 2'd0);

        // Back-to-back with both sides always willing.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        last_acc      = 0;
        for (int i = 0; i < 3; i++) begin
            bus.sum_row   = 64'h1111_0000_0000_0000 * (i + 1) + 64'hFFFF;
            bus.carry_row = 64'h0000_0F0F_0000_8000 + i;
            wait_accept();
            if (i > 0) check("b2b_gap", cyc - last_acc, NCHUNK + 2);
            last_acc = cyc;
        end
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("b2b_last_result", bus.result,
              64'h3333_0000_0000_FFFF + {64'h0000_0F0F_0000_8002, 1'b0});
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", bus.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_row_resolver.md
# csa_row_resolver

Sequential carry-propagate resolver that consumes the redundant SUM/CARRY row pair produced by the 16x64 partial-product compressor tree and converts it into a single binary result. The CARRY row carries weight i+1, so it is added shifted left by one. The 64-bit addition is done in CHUNK-bit slices, one slice per cycle, with a registered carry between slices. The block sits between the compressor tree and the multiplier result register, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 64: row width in bits. Must be a multiple of CHUNK.
- CHUNK, 16: bits resolved per cycle. NCHUNK = WIDTH/CHUNK (4 by default).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sum_row/carry_row are valid.
- in_ready  output  1  block can accept a row pair. High only in IDLE.
- sum_row  input  WIDTH  SUM row; each bit has weight i.
- carry_row  input  WIDTH  CARRY row; each bit has weight i+1.
- out_valid  output  1  result and ovf are valid. High only in DONE.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  (sum_row + (carry_row<<1)) mod 2^WIDTH.
- ovf  output  2  bits [WIDTH+1:WIDTH] of the exact sum.
- busy  output  1  high in ADD or DONE.

## Operation
- Operand handling:
  - Operand B = {carry_row[WIDTH-2:0], 1'b0}.
  - carry_row[WIDTH-1] is held aside and contributes only to ovf.
- The input is captured when in_valid && in_ready. Both rows are copied into internal registers. Inputs are not sampled again until the next IDLE.
- FSM states:
  - IDLE
    - in_ready=1.
    - On accept: capture both rows, set idx=0 and carry register cy=0, go to ADD.
  - ADD
    - Each cycle: {c, s} = A[idx slice] + B[idx slice] + cy. Write s into result[idx slice]; cy <= c; idx <= idx+1.
    - When idx == NCHUNK-1: ovf <= c + carry_row_msb (2-bit, zero-extended add), go to DONE.
  - DONE
    - out_valid=1. result and ovf are held stable.
    - On out_valid && out_ready: go to IDLE.
    - result and ovf keep their values until the next transaction overwrites them.
- Slices are processed LSB slice first.
- ovf range is 0..2. The value 3 is unreachable.
- in_valid is ignored outside IDLE. No input buffering.
- Reset, asynchronous, at any time including mid-ADD:
  - state=IDLE, idx=0, cy=0.
  - result=0, ovf=0, captured rows=0.
  - in_ready=1, out_valid=0, busy=0.
  - The partial result is discarded and no output handshake occurs.

## Timing
- Accept at edge N.
- ADD slices are computed at edges N+1 .. N+NCHUNK.
- out_valid is high from edge N+NCHUNK onward (after edge N+4 by default).
- Latency from accept to out_valid is NCHUNK cycles.
- If out_ready is high in the first DONE cycle, the output handshake occurs at edge N+NCHUNK+1. in_ready is high in the next cycle, so the earliest next accept is at edge N+NCHUNK+2.
- Throughput is one result per NCHUNK+2 cycles (6 by default).
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. Handshake outputs are state decodes only.
- out_valid, once high, stays high with stable result/ovf until the handshake completes.

## Test plan
- Simple add: sum_row=0x5, carry_row=0x3 -> result=0xB, ovf=0. out_valid rises exactly 4 cycles after accept.
- Cross-slice carry: sum_row=0xFFFF, carry_row=0x1 -> result=0x1_0001, ovf=0.
- Full ripple:
  - sum_row=0xFFFF_FFFF_FFFF_FFFF, carry_row=0x1 -> result=0x1, ovf=1.
  - Same sum_row, carry_row=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFD, ovf=2.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data.
  - Required: result/ovf stable, in_ready=0, new data not captured.
  - After out_ready=1, the next accept captures the data present at that time.
- Reset mid-operation: assert rst_n=0 after the second ADD slice -> outputs are 0 immediately (asynchronously). After release, in_ready=1, and a fresh sum_row=0x5/carry_row=0x3 yields 0xB.
- Back-to-back: out_ready tied high, in_valid tied high with 3 distinct row pairs -> 3 correct results, accepts exactly 6 cycles apart.
